// File: rtl/pygmy_pkg.sv
// Shared encodings and types for the pygmy core's load/store path.
package pygmy_pkg;

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_FAULT    = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        REQ  = 3'b010,
        RESP = 3'b100
    } lsu_state_t;

    // Illegal size or an address that does not sit on its natural boundary.
    function automatic logic misaligned(input logic [1:0] hb, input logic [1:0] addr_lo);
        return (hb == 2'b11) ||
               ((hb == HB_WORD) && (addr_lo != 2'b00)) ||
               ((hb == HB_HALF) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of a low-aligned RAM read lane according to access size.
module lsu_load_ext
    import pygmy_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  hb,
    input  logic        uload,
    output logic [31:0] ext_data
);

    always_comb begin
        ext_data = data;
        if (!uload) begin
            case (hb)
                HB_BYTE: ext_data = {{24{data[7]}}, data[7:0]};
                HB_HALF: ext_data = {{16{data[15]}}, data[15:0]};
                default: ext_data = data;
            endcase
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one operation at a time from execute to the data RAM req/gnt port.
//
// state | meaning
// IDLE  | waiting for valid_i; request checked on accept
// REQ   | mem_req_o high, fields held, waiting for grant or timeout
// RESP  | done_o pulse with registered rdata/err/cause
module lsu
    import pygmy_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter int unsigned RAM_BYTES = 4096,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic        we_i,
    input  logic [1:0]  hb_i,
    input  logic        uload_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [1:0]  cause_o,
    output logic        mem_req_o,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic        mem_uload_o,
    output logic [1:0]  mem_hb_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [32:0]   RAM_END  = {1'b0, RAM_BASE} + 33'(RAM_BYTES);

    lsu_state_t    state_q;
    logic          req_we_q;
    logic          req_uload_q;
    logic [1:0]    req_hb_q;
    logic [31:0]   req_addr_q;
    logic [31:0]   req_wdata_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [1:0]    cause_q;
    logic [31:0]   ext_data;
    logic          bad_align;
    logic          in_range;

    assign bad_align = misaligned(hb_i, addr_i[1:0]);
    assign in_range  = (addr_i >= RAM_BASE) && ({1'b0, addr_i} < RAM_END);

    lsu_load_ext u_load_ext (
        .data     (mem_rdata_i),
        .hb       (req_hb_q),
        .uload    (req_uload_q),
        .ext_data (ext_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_uload_q <= 1'b0;
            req_hb_q    <= 2'b00;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
            cnt_q       <= '0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        req_we_q    <= we_i;
                        req_uload_q <= uload_i;
                        req_hb_q    <= hb_i;
                        req_addr_q  <= addr_i;
                        req_wdata_q <= wdata_i;
                        if (bad_align) begin
                            state_q <= RESP;
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                            cause_q <= CAUSE_MISALIGN;
                        end else if (!in_range) begin
                            state_q <= RESP;
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                            cause_q <= CAUSE_FAULT;
                        end else begin
                            state_q <= REQ;
                            cnt_q   <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        state_q <= RESP;
                        rdata_q <= req_we_q ? 32'h0 : ext_data;
                        err_q   <= 1'b0;
                        cause_q <= CAUSE_NONE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= RESP;
                        rdata_q <= 32'h0;
                        err_q   <= 1'b1;
                        cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == RESP);
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign cause_o     = cause_q;
    assign mem_req_o   = (state_q == REQ);
    assign mem_ce_o    = (state_q == REQ);
    // Write enable is qualified so a finished store never lingers on the port.
    assign mem_we_o    = (state_q == REQ) && req_we_q;
    assign mem_uload_o = req_uload_q;
    assign mem_hb_o    = req_hb_q;
    assign mem_addr_o  = req_addr_q;
    assign mem_wdata_o = req_wdata_q;

endmodule
